// File: rtl/countdown_ctrl.sv
// Keypad countdown timer: digit entry, tick countdown, idle blanking.
// Define COUNTDOWN_PAUSE_EN to let start toggle RUN <-> PAUSE.
module countdown_ctrl #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 20,
  parameter int MULT    = 2,
  parameter int TIMEOUT = 10,
  localparam int VAL_W = $clog2(MAX_VAL+1),
  localparam int REM_W = $clog2(MAX_VAL*MULT+1),
  localparam int IDL_W = $clog2(TIMEOUT+1),
  localparam int CNT_W = $clog2(DIGITS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             key_num,
  input  logic             key_start,
  input  logic             key_clear,
  input  logic             key_confirm,
  input  logic [3:0]       num,
  output logic             display,
  output logic [VAL_W-1:0] input_val,
  output logic [REM_W-1:0] remaining,
  output logic [2:0]       state,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMPTY = 3'd1,
    ENTRY = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4
  } st_t;

  st_t              st_q, st_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [IDL_W-1:0] idl_q, idl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             disp_q, disp_d;
  logic             done_q, done_d;
  logic [4:0]       lvl_q;
  logic [4:0]       lvl;
  logic [4:0]       ev;
  logic             tick_ev, num_ev, start_ev, clr_ev, cfm_ev;
  int unsigned      ext;

  assign lvl = {tick, key_num, key_start, key_clear, key_confirm};
  assign ev  = lvl & ~lvl_q;
  assign {tick_ev, num_ev, start_ev, clr_ev, cfm_ev} = ev;

  // Level history resets high so a key held through reset is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      val_q  <= '0;
      rem_q  <= '0;
      idl_q  <= '0;
      cnt_q  <= '0;
      disp_q <= 1'b0;
      done_q <= 1'b0;
      lvl_q  <= '1;
    end else begin
      st_q   <= st_d;
      val_q  <= val_d;
      rem_q  <= rem_d;
      idl_q  <= idl_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      done_q <= done_d;
      lvl_q  <= lvl;
    end
  end

  always_comb begin
    st_d   = st_q;
    val_d  = val_q;
    rem_d  = rem_q;
    idl_d  = idl_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    done_d = 1'b0;
    ext    = '0;

    if (tick_ev) begin
      unique case (st_q)
        RUN: begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            st_d   = EMPTY;
            val_d  = '0;
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end
        EMPTY, ENTRY, PAUSE: begin
          if (idl_q >= IDL_W'(TIMEOUT-1)) begin
            st_d   = IDLE;
            disp_d = 1'b0;
            idl_d  = '0;
          end else begin
            idl_d = idl_q + IDL_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Keys see the post-tick state; only the highest-priority one acts.
    if (|{num_ev, start_ev, clr_ev, cfm_ev})
      idl_d = '0;

    if (clr_ev) begin
      if (st_d == ENTRY || st_d == PAUSE) begin
        st_d  = EMPTY;
        val_d = '0;
        rem_d = '0;
        cnt_d = '0;
      end
    end else if (start_ev) begin
      if (st_d == IDLE) begin
        st_d   = EMPTY;
        disp_d = 1'b1;
        val_d  = '0;
        rem_d  = '0;
        cnt_d  = '0;
      end
`ifdef COUNTDOWN_PAUSE_EN
      else if (st_d == RUN)
        st_d = PAUSE;
      else if (st_d == PAUSE)
        st_d = RUN;
`endif
    end else if (num_ev) begin
      if (num <= 4'd9 && cnt_d != CNT_W'(DIGITS) &&
          (st_d == ENTRY || (st_d == EMPTY && num != 4'd0))) begin
        ext   = 32'(val_d) * 32'd10 + 32'(num);
        val_d = (ext > 32'(MAX_VAL)) ? VAL_W'(MAX_VAL)
                                     : VAL_W'(ext);
        rem_d = REM_W'(32'(val_d) * 32'(MULT));
        cnt_d = cnt_d + CNT_W'(1);
        st_d  = ENTRY;
      end
    end else if (cfm_ev) begin
      if (st_d == ENTRY)
        st_d = RUN;
    end

    if (st_d == IDLE || st_d == RUN)
      idl_d = '0;
  end

  always_comb begin
    state     = st_q;
    display   = disp_q;
    input_val = val_q;
    remaining = rem_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a scoreboard of expected outputs.
// Expectations follow COUNTDOWN_PAUSE_EN when it is defined.
module tb_countdown_ctrl;
  localparam int VAL_W = 5;
  localparam int REM_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             key_num = 1'b0;
  logic             key_start = 1'b0;
  logic             key_clear = 1'b0;
  logic             key_confirm = 1'b0;
  logic [3:0]       num = 4'd0;
  logic             display;
  logic [VAL_W-1:0] input_val;
  logic [REM_W-1:0] remaining;
  logic [2:0]       state;
  logic             done;

  countdown_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .key_num(key_num), .key_start(key_start),
    .key_clear(key_clear), .key_confirm(key_confirm),
    .num(num), .display(display), .input_val(input_val),
    .remaining(remaining), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [2:0]       st;
    logic             disp;
    logic [VAL_W-1:0] val;
    logic [REM_W-1:0] rem;
    logic             dn;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [2:0]       e_st;
  logic             e_disp;
  logic [VAL_W-1:0] e_val;
  logic [REM_W-1:0] e_rem;
  logic             e_dn;

  task automatic expv(input int s, input int d,
                      input int v, input int r);
    e_st   = 3'(s);
    e_disp = d[0];
    e_val  = VAL_W'(v);
    e_rem  = REM_W'(r);
    e_dn   = 1'b0;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag  = tag;
    e.st   = e_st;
    e.disp = e_disp;
    e.val  = e_val;
    e.rem  = e_rem;
    e.dn   = e_dn;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: empty queue");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s state got %0d exp %0d", e.tag, state, e.st);
      end
      checks++;
      assert (display === e.disp) else begin
        errors++;
        $error("FAIL %s display got %0b exp %0b",
               e.tag, display, e.disp);
      end
      checks++;
      assert (input_val === e.val) else begin
        errors++;
        $error("FAIL %s input_val got %0d exp %0d",
               e.tag, input_val, e.val);
      end
      checks++;
      assert (remaining === e.rem) else begin
        errors++;
        $error("FAIL %s remaining got %0d exp %0d",
               e.tag, remaining, e.rem);
      end
      checks++;
      assert (done === e.dn) else begin
        errors++;
        $error("FAIL %s done got %0b exp %0b", e.tag, done, e.dn);
      end
    end
  endtask

  task automatic step(input string tag, input logic t,
                      input logic kn, input logic ks,
                      input logic kc, input logic kf,
                      input logic [3:0] n);
    tick        = t;
    key_num     = kn;
    key_start   = ks;
    key_clear   = kc;
    key_confirm = kf;
    num         = n;
    push(tag);
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic pulse(input string tag, input logic t,
                       input logic kn, input logic ks,
                       input logic kc, input logic kf,
                       input logic [3:0] n);
    step(tag, t, kn, ks, kc, kf, n);
    e_dn = 1'b0;
    step({tag, "_lo"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
  endtask

  initial begin
    expv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    push("reset");
    sample();
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 0);

    // Basic countdown of 15 units = 30 ticks
    expv(1, 1, 0, 0);   pulse("start", 0, 0, 1, 0, 0, 0);
    expv(2, 1, 1, 2);   pulse("num1", 0, 1, 0, 0, 0, 1);
    expv(2, 1, 15, 30); pulse("num5", 0, 1, 0, 0, 0, 5);
    expv(3, 1, 15, 30); pulse("confirm", 0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 30; i++) begin
      expv(3, 1, 15, 30 - i);
      pulse("run_tick", 1, 0, 0, 0, 0, 0);
    end
    expv(1, 1, 0, 0); e_dn = 1'b1;
    pulse("tick_done", 1, 0, 0, 0, 0, 0);

    // Saturation, digit limit, leading zero
    expv(2, 1, 3, 6);   pulse("num3", 0, 1, 0, 0, 0, 3);
    expv(2, 1, 20, 40); pulse("num7_sat", 0, 1, 0, 0, 0, 7);
    pulse("num_third", 0, 1, 0, 0, 0, 2);
    pulse("num_gt9", 0, 1, 0, 0, 0, 12);
    expv(1, 1, 0, 0);   pulse("clear", 0, 0, 0, 1, 0, 0);
    pulse("num_zero", 0, 1, 0, 0, 0, 0);

    // Inactivity timeout
    expv(2, 1, 4, 8);   pulse("num4", 0, 1, 0, 0, 0, 4);
    for (int i = 0; i < 9; i++)
      pulse("idle_entry", 1, 0, 0, 0, 0, 0);
    expv(1, 1, 0, 0);   pulse("clear_idle", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++)
      pulse("idle_empty", 1, 0, 0, 0, 0, 0);
    expv(0, 0, 0, 0);   pulse("timeout", 1, 0, 0, 0, 0, 0);

    // Same-cycle events
    expv(1, 1, 0, 0);   pulse("start2", 0, 0, 1, 0, 0, 0);
    expv(2, 1, 1, 2);   pulse("num1b", 0, 1, 0, 0, 0, 1);
    expv(3, 1, 1, 2);   pulse("confirm2", 0, 0, 0, 0, 1, 0);
    expv(3, 1, 1, 1);   pulse("tick_to1", 1, 0, 0, 0, 0, 0);
    expv(1, 1, 0, 0); e_dn = 1'b1;
    pulse("tick_cfm", 1, 0, 0, 0, 1, 0);
    expv(2, 1, 3, 6);   pulse("num3b", 0, 1, 0, 0, 0, 3);
    expv(1, 1, 0, 0);   pulse("clr_num", 0, 1, 0, 1, 0, 4);

    // Start while running
    expv(2, 1, 5, 10);  pulse("num5b", 0, 1, 0, 0, 0, 5);
    expv(3, 1, 5, 10);  pulse("confirm3", 0, 0, 0, 0, 1, 0);
`ifdef COUNTDOWN_PAUSE_EN
    expv(4, 1, 5, 10);  pulse("pause", 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      pulse("pause_tick", 1, 0, 0, 0, 0, 0);
    expv(3, 1, 5, 10);  pulse("resume", 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      expv(3, 1, 5, 10 - i);
      pulse("resume_tick", 1, 0, 0, 0, 0, 0);
    end
`else
    pulse("start_run", 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      expv(3, 1, 5, 10 - i);
      pulse("run_tick2", 1, 0, 0, 0, 0, 0);
    end
    pulse("start_run2", 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      expv(3, 1, 5, 5 - i);
      pulse("run_tick3", 1, 0, 0, 0, 0, 0);
    end
    pulse("clear_run", 0, 0, 0, 1, 0, 0);
`endif

    // Asynchronous reset mid-run with start held
    @(negedge clk);
    key_start = 1'b1;
    rst_n = 1'b0;
    #1;
    expv(0, 0, 0, 0);
    push("rst_async");
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_held", 0, 0, 1, 0, 0, 0);
    step("rst_held2", 0, 0, 1, 0, 0, 0);
    step("rst_release", 0, 0, 0, 0, 0, 0);
    expv(1, 1, 0, 0);   pulse("start3", 0, 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
